// File: rtl/bank_window_addrgen_pkg.sv
// Shared constants and helpers for the banked window address generator.
// Field layout of a node index: {row, lane, odd}.
package bank_window_addrgen_pkg;

  localparam int LANE_W_DEF  = 5;
  localparam int ROW_W_DEF   = 11;
  localparam int MEM_LAT_DEF = 1;
  localparam int MEM_LAT_MAX = 4;
  localparam int NBANKS_DEF  = 2 ** LANE_W_DEF;

  localparam int ODD_BIT  = 0;
  localparam int LANE_LSB = 1;

  function automatic int nbanks(input int lane_w);
    return 2 ** lane_w;
  endfunction

  function automatic int row_lsb(input int lane_w);
    return lane_w + 1;
  endfunction

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/bank_window_addrgen_dly_line.sv
// Enable-gated shift register with async reset.
// Every stage moves together so a stall never drops or duplicates data.
module addr_dly_line
  import bank_window_addrgen_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else if (i_en) begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/bank_window_addrgen.sv
// Decodes a node index into one row address per bank; banks below the
// lane offset read row+1. Lane/parity/ovf are delayed to meet RAM data.
module bank_window_addrgen
  import bank_window_addrgen_pkg::*;
#(
  parameter int LANE_W  = LANE_W_DEF,
  parameter int ROW_W   = ROW_W_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int WRAP    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic                          stall,
  input  logic [ROW_W+LANE_W:0]         addr_in,
  output logic [(2**LANE_W)*ROW_W-1:0]  bank_addr,
  output logic                          addr_valid,
  output logic [LANE_W-1:0]             sel,
  output logic                          odd,
  output logic                          out_valid,
  output logic                          ovf
);

  localparam int NBANKS = nbanks(LANE_W);
  localparam int RLSB   = row_lsb(LANE_W);
  localparam int DLY_W  = LANE_W + 3;

  if ((MEM_LAT < 1) || (MEM_LAT > MEM_LAT_MAX) || (LANE_W < 1) ||
      (ROW_W < 2) || (clog2_f(NBANKS) != LANE_W)) begin : g_bad_param
    $error("bank_window_addrgen: illegal parameters");
  end

  logic              w_odd;
  logic [LANE_W-1:0] w_lane;
  logic [ROW_W-1:0]  w_row;
  logic [ROW_W-1:0]  w_row_inc;
  logic [ROW_W-1:0]  w_row_p1;
  logic              w_row_max;
  logic              w_ovf_d;
  logic              w_en;

  assign w_odd     = addr_in[ODD_BIT];
  assign w_lane    = addr_in[LANE_W:LANE_LSB];
  assign w_row     = addr_in[ROW_W+LANE_W:RLSB];
  assign w_row_max = &w_row;
  assign w_row_inc = w_row + ROW_W'(1);
  // Saturating mode pins row+1 at all-ones instead of rolling over.
  assign w_row_p1  = (WRAP == 0 && w_row_max) ? '1 : w_row_inc;
  assign w_ovf_d   = w_row_max && (w_lane != '0);
  assign w_en      = !stall;

  logic [NBANKS*ROW_W-1:0] w_bank_nxt;
  logic [NBANKS*ROW_W-1:0] r_bank;
  logic                    r_addr_valid;

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    localparam logic [LANE_W-1:0] B = LANE_W'(b);
    assign w_bank_nxt[b*ROW_W +: ROW_W] = (B < w_lane) ? w_row_p1 : w_row;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank       <= '0;
      r_addr_valid <= 1'b0;
    end else if (w_en) begin
      r_bank       <= w_bank_nxt;
      r_addr_valid <= in_valid;
    end
  end

  assign bank_addr  = r_bank;
  assign addr_valid = r_addr_valid;

  logic [DLY_W-1:0] w_dly_in;
  logic [DLY_W-1:0] w_dly_out;

  assign w_dly_in = {in_valid, w_lane, w_odd, w_ovf_d};

  addr_dly_line #(
    .WIDTH (DLY_W),
    .DEPTH (1 + MEM_LAT)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_en),
    .i_d   (w_dly_in),
    .o_q   (w_dly_out)
  );

  assign {out_valid, sel, odd, ovf} = w_dly_out;

endmodule

// File: tb/tb_bank_window_addrgen.sv
// Self-checking bench: four instances (MEM_LAT 1..4, alternating WRAP)
// against a request-history model plus hand-computed expectations.
module tb_bank_window_addrgen;

  localparam int NK = 4;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       stall;
  logic [6:0] addr_in;

  logic [15:0] ba   [NK];
  logic        av   [NK];
  logic [1:0]  sl   [NK];
  logic        od   [NK];
  logic        ov   [NK];
  logic        of   [NK];

  for (genvar k = 0; k < NK; k++) begin : g_dut
    bank_window_addrgen #(
      .LANE_W  (2),
      .ROW_W   (4),
      .MEM_LAT (k + 1),
      .WRAP    ((k % 2 == 0) ? 1 : 0)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .stall      (stall),
      .addr_in    (addr_in),
      .bank_addr  (ba[k]),
      .addr_valid (av[k]),
      .sel        (sl[k]),
      .odd        (od[k]),
      .out_valid  (ov[k]),
      .ovf        (of[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    bit v;
    int row;
    int lane;
    bit odd;
  } req_t;

  req_t hist[$];

  always @(posedge clk or negedge rst_n) begin
    req_t t;
    if (!rst_n) begin
      hist.delete();
    end else if (!stall) begin
      t.v    = in_valid;
      t.row  = int'(addr_in[6:3]);
      t.lane = int'(addr_in[2:1]);
      t.odd  = addr_in[0];
      hist.push_back(t);
    end
  end

  function automatic logic [15:0] exp_banks(input req_t r, input bit wrap);
    logic [15:0] res;
    int a;
    res = '0;
    for (int b = 0; b < 4; b++) begin
      a = r.row + ((b < r.lane) ? 1 : 0);
      if (a > 15) a = wrap ? 0 : 15;
      res[b*4 +: 4] = a[3:0];
    end
    return res;
  endfunction

  function automatic bit exp_ovf(input req_t r);
    return (r.lane != 0) && (r.row == 15);
  endfunction

  always @(negedge clk) begin
    int n;
    int d;
    req_t r;
    n = hist.size();
    for (int k = 0; k < NK; k++) begin
      d = k + 2;
      if (n == 0) begin
        chk($sformatf("m%0d bank_addr", k), ba[k], 16'h0);
        chk($sformatf("m%0d addr_valid", k), av[k], 1'b0);
      end else begin
        r = hist[n-1];
        chk($sformatf("m%0d addr_valid", k), av[k], r.v);
        if (r.v)
          chk($sformatf("m%0d bank_addr", k), ba[k],
              exp_banks(r, (k % 2) == 0));
      end
      if (n < d) begin
        chk($sformatf("m%0d out_valid", k), ov[k], 1'b0);
        chk($sformatf("m%0d sel/odd/ovf", k), {sl[k], od[k], of[k]}, 4'h0);
      end else begin
        r = hist[n-d];
        chk($sformatf("m%0d out_valid", k), ov[k], r.v);
        if (r.v) begin
          chk($sformatf("m%0d sel", k), sl[k], r.lane[1:0]);
          chk($sformatf("m%0d odd", k), od[k], r.odd);
          chk($sformatf("m%0d ovf", k), of[k], exp_ovf(r));
        end
      end
    end
  end

  task automatic drive(input bit v, input int row, input int lane,
                       input bit o, input bit st);
    in_valid = v;
    stall    = st;
    addr_in  = {row[3:0], lane[1:0], o};
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int lat [NK];
  int cnt [NK];

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (3) cyc();
    @(negedge clk);
    for (int k = 0; k < NK; k++) begin
      chk($sformatf("reset bank k%0d", k), ba[k], 16'h0);
      chk($sformatf("reset outs k%0d", k),
          {av[k], ov[k], sl[k], od[k], of[k]}, 6'h0);
    end
    rst_n = 1'b1;
    cyc();

    // basic decode: row 5, lane 2, odd 1
    drive(1, 5, 2, 1, 0);
    cyc();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("decode banks", ba[0], 16'h5566);
    chk("decode addr_valid", av[0], 1'b1);
    cyc();
    @(negedge clk);
    chk("decode out_valid", ov[0], 1'b1);
    chk("decode sel", sl[0], 2'd2);
    chk("decode odd", od[0], 1'b1);
    chk("decode ovf", of[0], 1'b0);
    repeat (6) cyc();

    // row max edge in both modes, then lane 0 at the same row
    drive(1, 15, 3, 0, 0);
    cyc();
    drive(1, 15, 0, 1, 0);
    @(negedge clk);
    chk("wrap banks", ba[0], 16'hF000);
    chk("sat banks", ba[1], 16'hFFFF);
    cyc();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lane0 banks wrap", ba[0], 16'hFFFF);
    chk("lane0 banks sat", ba[1], 16'hFFFF);
    chk("wrap ovf valid", ov[0], 1'b1);
    chk("wrap ovf", of[0], 1'b1);
    cyc();
    @(negedge clk);
    chk("lane0 out_valid", ov[0], 1'b1);
    chk("lane0 ovf", of[0], 1'b0);
    chk("lane0 odd", od[0], 1'b1);
    chk("sat ovf valid", ov[1], 1'b1);
    chk("sat ovf", of[1], 1'b1);
    repeat (6) cyc();

    // eight back-to-back requests -> eight out_valid cycles each instance
    for (int k = 0; k < NK; k++) cnt[k] = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 8)
        drive(1, $urandom_range(0, 15), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), 0);
      else
        drive(0, 0, 0, 0, 0);
      @(negedge clk);
      for (int k = 0; k < NK; k++) if (ov[k]) cnt[k]++;
      cyc();
    end
    for (int k = 0; k < NK; k++)
      chk($sformatf("stream count k%0d", k), cnt[k], 8);

    // three-cycle stall with valid pulses in the middle of a stream
    for (int i = 0; i < 11; i++) begin
      drive(1, $urandom_range(0, 15), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), (i >= 4 && i < 7));
      cyc();
    end
    drive(0, 0, 0, 0, 0);
    repeat (8) cyc();

    // latency sweep
    drive(1, 3, 1, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < NK; k++) lat[k] = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      for (int k = 0; k < NK; k++) if (ov[k] && lat[k] == 0) lat[k] = i;
    end
    for (int k = 0; k < NK; k++)
      chk($sformatf("latency k%0d", k), lat[k], k + 2);
    cyc();

    // random traffic with stalls and row-max bias
    for (int i = 0; i < 500; i++) begin
      drive(($urandom_range(0, 2) != 0),
            ($urandom_range(0, 3) == 0) ? 15 : $urandom_range(0, 15),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0));
      cyc();
    end

    // reset in the middle of a stream
    for (int i = 0; i < 3; i++) begin
      drive(1, $urandom_range(0, 15), $urandom_range(0, 3), 1'b1, 0);
      cyc();
    end
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NK; k++)
      chk($sformatf("midreset outs k%0d", k),
          {ba[k], av[k], ov[k], sl[k], od[k], of[k]}, 22'h0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      @(negedge clk);
      for (int k = 0; k < NK; k++)
        chk($sformatf("post-reset quiet k%0d", k), ov[k], 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
